// File: rtl/sccb_target_responder_if.sv
// sccb_target_responder_if: SCCB bus pins and external register-file port of the target responder.
interface sccb_target_responder_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       reg_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       wr_done;
  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_wr_en, reg_addr, reg_wdata, busy, wr_done
  );
  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_wr_en, reg_addr, reg_wdata, busy, wr_done
  );
endinterface

// File: rtl/sccb_target_responder.sv
// sccb_target_responder: oversampled SCCB/I2C target decoding register writes (burst, 8-bit pointer wrap).
// Register reads are served only when SCCB_TARGET_READ_EN is defined.
module sccb_target_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input logic                    clk,
  input logic                    reset,
  sccb_target_responder_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_REG, S_REG_ACK, S_VAL, S_VAL_ACK,
`ifdef SCCB_TARGET_READ_EN
    S_RD_BYTE, S_RD_ACK,
`endif
    S_IGNORE
  } state_t;
`ifdef SCCB_TARGET_READ_EN
  localparam bit RD_EN = 1'b1;
  logic       rd_q, rd_d;
  logic [7:0] rd_sh_q, rd_sh_d;
`else
  localparam bit RD_EN = 1'b0;
  logic [7:0] unused_rdata;
  assign unused_rdata = bus.reg_rdata;
`endif
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_h_q, scl_h_d, sda_h_q, sda_h_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             reg_addr_q, reg_addr_d;
  logic [7:0]             reg_wdata_q, reg_wdata_d;
  logic                   reg_wr_en_q, reg_wr_en_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   wr_done_q, wr_done_d;
  logic                   wrote_q, wrote_d;
  logic                   ack_ph_q, ack_ph_d;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start, stop;
  logic                   rx_state, byte_done;
  logic [7:0]             rx_byte;
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_h_d    = scl_s;
    sda_h_d    = sda_s;
    scl_rise   = scl_s & ~scl_h_q;
    scl_fall   = ~scl_s & scl_h_q;
    // SCL must be high in both samples, so an SCL edge never doubles as START/STOP
    start      = scl_s & scl_h_q & ~sda_s & sda_h_q;
    stop       = scl_s & scl_h_q & sda_s & ~sda_h_q;
    rx_state   = state_q == S_DEV || state_q == S_REG || state_q == S_VAL;
    rx_byte    = {shift_q[6:0], sda_s};
    byte_done  = scl_rise && bit_cnt_q == 4'd7;
  end
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_en_d = 1'b0;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_done_d   = 1'b0;
    wrote_d     = wrote_q;
    ack_ph_d    = ack_ph_q;
`ifdef SCCB_TARGET_READ_EN
    rd_d        = rd_q;
    rd_sh_d     = rd_sh_q;
`endif
    if (stop) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      wr_done_d = wrote_q;
      wrote_d   = 1'b0;
    end else if (start) begin
      state_d   = S_DEV;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      ack_ph_d  = 1'b0;
    end else begin
      if (rx_state && scl_rise) begin
        shift_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      case (state_q)
        S_DEV: if (byte_done) begin
          ack_ph_d = 1'b0;
          if (rx_byte[7:1] == DEV_ADDR && (!rx_byte[0] || RD_EN)) begin
            state_d = S_DEV_ACK;
            busy_d  = 1'b1;
          end else state_d = S_IGNORE;
`ifdef SCCB_TARGET_READ_EN
          rd_d = rx_byte[0];
`endif
        end
        S_REG: if (byte_done) begin
          reg_addr_d = rx_byte;
          ack_ph_d   = 1'b0;
          state_d    = S_REG_ACK;
        end
        S_VAL: if (byte_done) begin
          reg_wdata_d = rx_byte;
          reg_wr_en_d = 1'b1;
          wrote_d     = 1'b1;
          ack_ph_d    = 1'b0;
          state_d     = S_VAL_ACK;
        end
        S_DEV_ACK, S_REG_ACK, S_VAL_ACK: if (scl_fall) begin
          if (!ack_ph_q) begin
            sda_oe_d = 1'b1;
            ack_ph_d = 1'b1;
          end else begin
            sda_oe_d   = 1'b0;
            ack_ph_d   = 1'b0;
            bit_cnt_d  = 4'd0;
            state_d    = state_q == S_DEV_ACK ? S_REG : S_VAL;
            reg_addr_d = state_q == S_VAL_ACK ? reg_addr_q + 8'd1 : reg_addr_q;
`ifdef SCCB_TARGET_READ_EN
            // the ACK-release edge also puts the first read bit on the bus
            if (state_q == S_DEV_ACK && rd_q) begin
              state_d  = S_RD_BYTE;
              rd_sh_d  = bus.reg_rdata;
              sda_oe_d = ~bus.reg_rdata[7];
            end
`endif
          end
        end
`ifdef SCCB_TARGET_READ_EN
        S_RD_BYTE: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ack_ph_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d = ~rd_sh_q[6];
              rd_sh_d  = {rd_sh_q[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end else begin
              reg_addr_d = reg_addr_q + 8'd1;
              ack_ph_d   = 1'b1;
            end
          end else if (scl_fall && ack_ph_q) begin
            state_d   = S_RD_BYTE;
            bit_cnt_d = 4'd0;
            ack_ph_d  = 1'b0;
            rd_sh_d   = bus.reg_rdata;
            sda_oe_d  = ~bus.reg_rdata[7];
          end
        end
`endif
        S_IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_h_q     <= 1'b1;
      sda_h_q     <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_wr_en_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      wrote_q     <= 1'b0;
      ack_ph_q    <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
      rd_q        <= 1'b0;
      rd_sh_q     <= 8'h00;
`endif
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_h_q     <= scl_h_d;
      sda_h_q     <= sda_h_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_en_q <= reg_wr_en_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_done_q   <= wr_done_d;
      wrote_q     <= wrote_d;
      ack_ph_q    <= ack_ph_d;
`ifdef SCCB_TARGET_READ_EN
      rd_q        <= rd_d;
      rd_sh_q     <= rd_sh_d;
`endif
    end
  end
  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_wr_en = reg_wr_en_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.wr_done   = wr_done_q;
endmodule

// File: tb/tb_sccb_target_responder.sv
// tb_sccb_target_responder: bit-level SCCB master with scoreboard queues for ACK/read bits, writes and wr_done.
module tb_sccb_target_responder;
  localparam int Q = 100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic sda_drv = 1'b1;
  logic slot = 1'b0;
  int checks = 0;
  int errors = 0;
  logic bit_q[$];
  logic [15:0] wr_q[$];
  logic done_q[$];
  sccb_target_responder_if bus ();
  assign bus.scl_in = scl;
  assign bus.sda_in = sda_drv & ~bus.sda_oe;
  assign bus.reg_rdata = 8'h76;
  sccb_target_responder #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  // slave-owned bits are compared against the queue; elsewhere the target must not pull SDA
  always @(posedge scl) begin
    if (slot) begin
      checks++;
      if (bit_q.size() == 0) begin
        errors++;
        $display("FAIL sda_bit unexpected got=%b", bus.sda_in);
      end else begin
        logic eb;
        eb = bit_q.pop_front();
        if (bus.sda_in !== eb) begin
          errors++;
          $display("FAIL sda_bit got=%b want=%b", bus.sda_in, eb);
        end
      end
    end else if (!reset) begin
      checks++;
      if (bus.sda_oe !== 1'b0) begin
        errors++;
        $display("FAIL sda_oe_master_bit got=%b want=0", bus.sda_oe);
      end
    end
  end
  always @(negedge clk) begin
    if (!reset && bus.reg_wr_en) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL reg_write unexpected got=%h%h", bus.reg_addr, bus.reg_wdata);
      end else begin
        logic [15:0] ew;
        ew = wr_q.pop_front();
        if ({bus.reg_addr, bus.reg_wdata} !== ew) begin
          errors++;
          $display("FAIL reg_write got=%h%h want=%h", bus.reg_addr, bus.reg_wdata, ew);
        end
      end
    end
    if (!reset && bus.wr_done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL wr_done unexpected got=1 want=0");
      end else void'(done_q.pop_front());
    end
  end
  task automatic put_bit(input logic b, input logic s);
    sda_drv = b;
    slot = s;
    #(Q);
    scl = 1'b1;
    #(2*Q);
    scl = 1'b0;
    #(Q);
    slot = 1'b0;
  endtask
  task automatic send_start();
    sda_drv = 1'b1;
    #(Q);
    scl = 1'b1;
    #(Q);
    sda_drv = 1'b0;
    #(Q);
    scl = 1'b0;
    #(Q);
  endtask
  task automatic send_stop();
    sda_drv = 1'b0;
    #(Q);
    scl = 1'b1;
    #(Q);
    sda_drv = 1'b1;
    #(2*Q);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i], 1'b0);
    bit_q.push_back(exp_ack);
    put_bit(1'b1, 1'b1);
  endtask
  task automatic read_byte(input logic [7:0] exp, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      bit_q.push_back(exp[i]);
      put_bit(1'b1, 1'b1);
    end
    put_bit(mack, 1'b0);
  endtask
  initial begin
    #(3000000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", {15'd0, bus.sda_oe}, 16'h0);
    chk("rst_wr_en", {15'd0, bus.reg_wr_en}, 16'h0);
    chk("rst_addr", {8'd0, bus.reg_addr}, 16'h0);
    chk("rst_wdata", {8'd0, bus.reg_wdata}, 16'h0);
    chk("rst_busy", {15'd0, bus.busy}, 16'h0);
    chk("rst_wr_done", {15'd0, bus.wr_done}, 16'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    // single write 12 <= 80
    send_start();
    send_byte(8'h42, 1'b0);
    chk("busy_after_addr", {15'd0, bus.busy}, 16'h1);
    send_byte(8'h12, 1'b0);
    wr_q.push_back(16'h1280);
    send_byte(8'h80, 1'b0);
    done_q.push_back(1'b1);
    send_stop();
    chk("busy_after_stop", {15'd0, bus.busy}, 16'h0);
    // foreign address: nothing acknowledged or written
    send_start();
    send_byte(8'h44, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h80, 1'b1);
    chk("busy_foreign", {15'd0, bus.busy}, 16'h0);
    send_stop();
    // burst with pointer wrap FF -> 00
    send_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'hFF, 1'b0);
    wr_q.push_back(16'hFF11);
    send_byte(8'h11, 1'b0);
    wr_q.push_back(16'h0022);
    send_byte(8'h22, 1'b0);
    chk("burst_addr_wrapped", {8'd0, bus.reg_addr}, 16'h0001);
    done_q.push_back(1'b1);
    send_stop();
    // set pointer to 0A, then attempt a read
    send_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_stop();
    send_start();
`ifdef SCCB_TARGET_READ_EN
    send_byte(8'h43, 1'b0);
    read_byte(8'h76, 1'b1);
    chk("read_busy_after_nack", {15'd0, bus.busy}, 16'h0);
`else
    send_byte(8'h43, 1'b1);
    chk("read_busy_no_ack", {15'd0, bus.busy}, 16'h0);
`endif
    chk("read_addr_kept", {8'd0, bus.reg_addr}, 16'h000A);
    send_stop();
    // STOP after 4 value bits discards the byte
    send_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h12, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(i[0], 1'b0);
    send_stop();
    chk("partial_busy", {15'd0, bus.busy}, 16'h0);
    // repeated START inside the register byte restarts address decoding
    send_start();
    send_byte(8'h42, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(1'b0, 1'b0);
    send_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h30, 1'b0);
    wr_q.push_back(16'h3055);
    send_byte(8'h55, 1'b0);
    done_q.push_back(1'b1);
    send_stop();
    // reset while the address ACK holds SDA low
    send_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 6 || i == 1, 1'b0);
    for (int i = 0; i < 40 && !bus.sda_oe; i++) @(negedge clk);
    chk("ack_driven_before_reset", {15'd0, bus.sda_oe}, 16'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("reset_async_release", {15'd0, bus.sda_oe}, 16'h0);
    #46;
    reset = 1'b0;
    send_stop();
    send_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h5A, 1'b0);
    wr_q.push_back(16'h5AC3);
    send_byte(8'hC3, 1'b0);
    done_q.push_back(1'b1);
    send_stop();
    repeat (10) @(negedge clk);
    chk("pending_bits", bit_q.size(), 16'h0);
    chk("pending_writes", wr_q.size(), 16'h0);
    chk("pending_done", done_q.size(), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
